// File: rtl/deser_pkg.sv
// deser_pkg: shared FSM state type and bit-position helper for the bit deserializer.
package deser_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
    function automatic int bit_pos(input int idx, input int width, input bit msb_first);
        return msb_first ? width - 1 - idx : idx;
    endfunction
endpackage

// File: rtl/deser_bit_counter.sv
// deser_bit_counter: mod-WIDTH word index counter with synchronous clear and a last-position flag.
module deser_bit_counter #(
    parameter int WIDTH = 8,
    parameter int IW = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] idx,
    output logic          last
);
    assign last = idx == IW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) idx <= '0;
        else if (clr) idx <= '0;
        else if (inc) idx <= last ? '0 : idx + 1'b1;
endmodule

// File: rtl/bit_deserializer.sv
// bit_deserializer: serial-to-parallel receiver with a one-entry valid/ready output register.
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int IW = $clog2(WIDTH);
    state_t state, state_nxt;
    logic [WIDTH-1:0] asm, asm_nxt;
    logic [IW-1:0] idx, pos;
    logic last, acc, take, done, load_new, load_held;
    assign in_ready  = state != HOLD;
    assign acc       = in_valid & in_ready & ~clr;
    assign take      = out_valid & out_ready;
    assign done      = acc & last;
    assign load_new  = done & (~out_valid | take);
    // a completed word parked in asm drains as soon as the slot is taken, unless aborted
    assign load_held = (state == HOLD) & take & ~clr;
    assign pos       = IW'(bit_pos(int'(idx), WIDTH, MSB_FIRST != 0));
    deser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (acc),
        .idx  (idx),
        .last (last)
    );
    always_comb begin
        asm_nxt = asm;
        if (acc) asm_nxt[pos] = in_bit;
        state_nxt = clr       ? IDLE :
                    load_held ? IDLE :
                    done      ? (load_new ? IDLE : HOLD) :
                    acc       ? COLLECT : state;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            asm       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            asm       <= clr ? '0 : asm_nxt;
            out_data  <= load_new ? asm_nxt : load_held ? asm : out_data;
            out_valid <= load_new | load_held | (out_valid & ~take);
        end
endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: MSB-first and LSB-first instances driven in lockstep, checked against a queue-based word model.
module tb_bit_deserializer;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic rdy_m, rdy_l, ov_m, ov_l;
    logic [W-1:0] od_m, od_l;
    int vectors = 0, miscompares = 0;
    bit m_q[$];
    bit m_held_v, m_ov;
    logic [W-1:0] m_held, m_od;

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(rdy_m), .out_data(od_m), .out_valid(ov_m), .out_ready(out_ready));
    bit_deserializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(rdy_l), .out_data(od_l), .out_valid(ov_l), .out_ready(out_ready));

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        return {<<{x}};
    endfunction
    function automatic logic [2*W+3:0] got();
        return {rdy_m, ov_m, od_m, rdy_l, ov_l, od_l};
    endfunction
    function automatic logic [2*W+3:0] want();
        return {!m_held_v, m_ov, m_od, !m_held_v, m_ov, rev(m_od)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_held_v = 0;
        m_ov = 0;
        m_od = '0;
        m_held = '0;
    endtask

    // Drive one cycle, advance the word-level model across the edge, return at the next negedge.
    task automatic step(input bit c, input bit v, input bit b, input bit r);
        bit acc, take;
        logic [W-1:0] w;
        clr = c; in_valid = v; in_bit = b; out_ready = r;
        acc = v && !m_held_v;
        take = m_ov && r;
        @(posedge clk);
        if (c) begin
            m_q.delete();
            m_held_v = 0;
            if (take) m_ov = 0;
        end else if (m_held_v && take) begin
            m_od = m_held;
            m_held_v = 0;
        end else if (acc) begin
            m_q.push_back(b);
            if (m_q.size() == W) begin
                w = '0;
                foreach (m_q[i]) w = {w[W-2:0], m_q[i]};
                m_q.delete();
                if (!m_ov || take) begin m_od = w; m_ov = 1; end
                else begin m_held = w; m_held_v = 1; end
            end else if (take) m_ov = 0;
        end else if (take) m_ov = 0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] x, input bit r);
        for (int i = 0; i < W; i++) begin
            step(0, 1, x[W-1], r);
            x = x << 1;
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (got() !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_hold got %h want %h", got(), {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        vectors++;
        if (got() !== want()) begin
            miscompares++;
            $display("FAIL reset_release got %h want %h", got(), want());
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] s = 8'b1011_0011;
        for (int i = 0; i < W; i++) begin
            step(0, 1, s[W-1], 1);
            s = s << 1;
            vectors++;
            if (got() !== want()) begin
                miscompares++;
                $display("FAIL stream_bit%0d got %h want %h", i, got(), want());
            end
        end
        vectors++;
        if (!(ov_m === 1'b1 && od_m === 8'hB3 && ov_l === 1'b1 && od_l === 8'hCD)) begin
            miscompares++;
            $display("FAIL stream_word got %b/%h %b/%h want 1/b3 1/cd", ov_m, od_m, ov_l, od_l);
        end
        step(0, 0, 0, 1);
        vectors++;
        if (ov_m !== 1'b0 || ov_l !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_pulse got %b%b want 00", ov_m, ov_l);
        end
    endtask

    task automatic test_backpressure();
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        vectors++;
        if (!(rdy_m === 1'b0 && ov_m === 1'b1 && od_m === 8'hA5) || got() !== want()) begin
            miscompares++;
            $display("FAIL bp_hold got %h want %h (rdy0 ov1 a5)", got(), want());
        end
        step(0, 1, 1, 0);
        vectors++;
        if (od_m !== 8'hA5 || rdy_m !== 1'b0 || got() !== want()) begin
            miscompares++;
            $display("FAIL bp_stall got %h want %h", got(), want());
        end
        step(0, 0, 0, 1);
        vectors++;
        if (!(od_m === 8'h3C && ov_m === 1'b1 && rdy_m === 1'b1) || got() !== want()) begin
            miscompares++;
            $display("FAIL bp_drain got %h want %h (3c ov1 rdy1)", got(), want());
        end
        step(0, 0, 0, 1);
        vectors++;
        if (ov_m !== 1'b0 || got() !== want()) begin
            miscompares++;
            $display("FAIL bp_empty got %h want %h", got(), want());
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s = 8'h5A;
        send_word(8'h11, 0);
        for (int i = 0; i < W; i++) begin
            step(0, 1, s[W-1], i == W - 1);
            s = s << 1;
            vectors++;
            if (rdy_m !== 1'b1 || ov_m !== 1'b1 || got() !== want()) begin
                miscompares++;
                $display("FAIL b2b_bit%0d got %h want %h", i, got(), want());
            end
        end
        vectors++;
        if (od_m !== 8'h5A || od_l !== rev(8'h5A)) begin
            miscompares++;
            $display("FAIL b2b_word got %h %h want 5a %h", od_m, od_l, rev(8'h5A));
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_clr();
        repeat (3) step(0, 1, 1, 1);
        step(1, 1, 1, 1);
        vectors++;
        if (rdy_m !== 1'b1 || ov_m !== 1'b0 || got() !== want()) begin
            miscompares++;
            $display("FAIL clr_abort got %h want %h", got(), want());
        end
        send_word(8'h0F, 1);
        vectors++;
        if (!(od_m === 8'h0F && ov_m === 1'b1 && od_l === 8'hF0) || got() !== want()) begin
            miscompares++;
            $display("FAIL clr_word got %h %h want 0f f0", od_m, od_l);
        end
        send_word(8'hC3, 0);
        send_word(8'h77, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        vectors++;
        if (ov_m !== 1'b0 || rdy_m !== 1'b1 || got() !== want()) begin
            miscompares++;
            $display("FAIL clr_discard got %h want %h", got(), want());
        end
    endtask

    task automatic test_async_reset();
        send_word(8'hE1, 0);
        repeat (3) step(0, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (got() !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL async_reset got %h want %h", got(), {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_word(8'h96, 1);
        vectors++;
        if (!(od_m === 8'h96 && ov_m === 1'b1 && od_l === 8'h69) || got() !== want()) begin
            miscompares++;
            $display("FAIL post_reset_word got %h %h want 96 69", od_m, od_l);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            vectors++;
            if (got() !== want()) begin
                miscompares++;
                $display("FAIL random_%0d got %h want %h", i, got(), want());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
